// File: rtl/add_accumulator.sv
// Streaming 64-bit accumulator: two-stage capture/add pipeline with a sticky carry,
// a saturating operand count and a drain-then-readout sequence that clears the sum.
module add_accumulator #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_load,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_carry,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  logic             s1_valid;
  logic             s1_load;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] acc;
  logic             carry_sticky;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic [WIDTH:0]   sum;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ACCUM) || s1_valid;
  assign sum      = {1'b0, acc} + {1'b0, s1_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_load  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_load  <= in_load;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // The readout clear only fires once stage 1 is empty, so it never races the add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      carry_sticky <= 1'b0;
      count        <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_carry     <= 1'b0;
      rd_count     <= '0;
    end else begin
      if (s1_valid) begin
        if (s1_load) begin
          acc          <= s1_data;
          carry_sticky <= 1'b0;
          count        <= CNT_W'(1);
        end else begin
          acc          <= sum[WIDTH-1:0];
          carry_sticky <= carry_sticky | sum[WIDTH];
          if (count != '1) count <= count + CNT_W'(1);
        end
      end

      unique case (state)
        ACCUM: begin
          if (rd_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid) begin
            rd_data      <= acc;
            rd_carry     <= carry_sticky;
            rd_count     <= count;
            rd_valid     <= 1'b1;
            acc          <= '0;
            carry_sticky <= 1'b0;
            count        <= '0;
            state        <= OUT;
          end
        end
        OUT: begin
          rd_valid <= 1'b0;
          state    <= ACCUM;
        end
        default: begin
          rd_valid <= 1'b0;
          state    <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator; a second instance with a 4-bit counter
// shares all inputs so the count saturation can be observed alongside the default.
module tb_add_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_load;
  logic        rd_req;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_carry;
  logic [15:0] rd_count;
  logic        busy;

  logic        in_ready4;
  logic        rd_valid4;
  logic [63:0] rd_data4;
  logic        rd_carry4;
  logic [3:0]  rd_count4;
  logic        busy4;

  int n_checks = 0;
  int n_fails  = 0;

  add_accumulator #(.WIDTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_load(in_load), .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_carry(rd_carry), .rd_count(rd_count), .busy(busy)
  );

  add_accumulator #(.WIDTH(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_load(in_load), .rd_req(rd_req), .rd_valid(rd_valid4),
    .rd_data(rd_data4), .rd_carry(rd_carry4), .rd_count(rd_count4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one operand for exactly one accepting edge.
  task automatic applyStimulus(input logic [63:0] data, input logic load);
    in_valid = 1'b1;
    in_data  = data;
    in_load  = load;
    step();
    in_valid = 1'b0;
    in_load  = 1'b0;
  endtask

  task automatic request();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic expectRead(input string tag, input logic [63:0] d, input logic c,
                            input logic [15:0] n, input logic [3:0] n4);
    logic [63:0] held;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid === 1'b1) break;
      step();
    end
    checkOutput({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
    checkOutput({tag, " rd_data"}, rd_data, d);
    checkOutput({tag, " rd_carry"}, 64'(rd_carry), 64'(c));
    checkOutput({tag, " rd_count"}, 64'(rd_count), 64'(n));
    checkOutput({tag, " rd_valid4"}, 64'(rd_valid4), 64'd1);
    checkOutput({tag, " rd_count4"}, 64'(rd_count4), 64'(n4));
    held = rd_data;
    step();
    checkOutput({tag, " rd_valid fall"}, 64'(rd_valid), 64'd0);
    checkOutput({tag, " rd_data hold"}, rd_data, held);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_load  = 1'b0;
    rd_req   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] reset state");
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("reset rd_data", rd_data, 64'd0);
    checkOutput("reset rd_count", 64'(rd_count), 64'd0);

    $display("[TB] basic sum 5+7+0x10");
    applyStimulus(64'd5, 1'b0);
    applyStimulus(64'd7, 1'b0);
    applyStimulus(64'h10, 1'b0);
    request();
    checkOutput("drain in_ready", 64'(in_ready), 64'd0);
    checkOutput("drain busy", 64'(busy), 64'd1);
    expectRead("basic", 64'h1C, 1'b0, 16'd3, 4'd3);

    $display("[TB] carry-out wrap");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    applyStimulus(64'd2, 1'b0);
    request();
    expectRead("carry", 64'd1, 1'b1, 16'd2, 4'd2);
    applyStimulus(64'd3, 1'b0);
    request();
    expectRead("after clear", 64'd3, 1'b0, 16'd1, 4'd1);

    $display("[TB] rd_req with simultaneous operand");
    applyStimulus(64'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'd9;
    rd_req   = 1'b1;
    step();
    rd_req  = 1'b0;
    in_data = 64'h55;
    checkOutput("simul in_ready", 64'(in_ready), 64'd0);
    checkOutput("simul busy", 64'(busy), 64'd1);
    expectRead("simul", 64'hA, 1'b0, 16'd2, 4'd2);
    checkOutput("held in_ready back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    request();
    expectRead("held operand", 64'h55, 1'b0, 16'd1, 4'd1);

    $display("[TB] mid-stream load");
    applyStimulus(64'd100, 1'b0);
    applyStimulus(64'd200, 1'b0);
    applyStimulus(64'd50, 1'b1);
    applyStimulus(64'd25, 1'b0);
    request();
    expectRead("load", 64'd75, 1'b0, 16'd2, 4'd2);

    $display("[TB] count saturation");
    for (int i = 0; i < 20; i++) applyStimulus(64'd1, 1'b0);
    request();
    expectRead("saturate", 64'd20, 1'b0, 16'd20, 4'd15);

    $display("[TB] reset during drain");
    applyStimulus(64'h1234, 1'b0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    checkOutput("pre-reset in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst rd_data", rd_data, 64'd0);
    checkOutput("rst rd_carry", 64'(rd_carry), 64'd0);
    checkOutput("rst rd_count", 64'(rd_count), 64'd0);
    checkOutput("rst in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst no pulse", 64'(rd_valid), 64'd0);
    end
    rst_n = 1'b1;
    step();
    checkOutput("post-rst no pulse", 64'(rd_valid), 64'd0);
    request();
    expectRead("empty", 64'd0, 1'b0, 16'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
